// File: rtl/wb_qspi_arbiter.sv
// Shares one QSPI memory controller between the instruction and data Wishbone buses.
// Latency: grant registers the request (mem_stb_o one cycle after stb), master ack rides on mem_ack_i; buffer hits and ROM writes ack after one cycle.
// Backpressure: one transaction outstanding; a master holds stb until its ack, and the losing bus waits in place until the arbiter returns to IDLE.
module wb_qspi_arbiter #(
  parameter int SEL_BIT  = 24,
  parameter bit USE_IBUF = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_in,
  // instruction bus
  input  logic        ibus_stb_i,
  input  logic [31:0] ibus_adr_i,
  output logic        ibus_ack_o,
  output logic [31:0] ibus_dat_o,
  // data bus
  input  logic        dbus_stb_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_be_i,
  input  logic [31:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  output logic        dbus_ack_o,
  output logic [31:0] dbus_dat_o,
  // fetch buffer invalidate (fence.i)
  input  logic        flush_i,
  // QSPI controller side
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_dat_o,
  output logic [21:0] mem_adr_o,
  output logic        sel_rom_ram_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MEM_I = 3'd1,
    S_MEM_D = 3'd2,
    S_HIT   = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;      // 1 = data bus won the previous grant
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdat_q, wdat_d;
  logic [21:0] adr_q, adr_d;
  logic        sel_q, sel_d;
  logic        buf_vld_q, buf_vld_d;
  logic [21:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_dat_q, buf_dat_d;

  // Arbitration terms, only acted upon in IDLE
  logic pick_d, pick_i, ibuf_hit, rom_wr, ram_wr_grant, mem_done;

  assign pick_d       = dbus_stb_i && (!ibus_stb_i || !last_q);
  assign pick_i       = ibus_stb_i && !pick_d;
  assign ibuf_hit     = USE_IBUF && buf_vld_q && (buf_tag_q == ibus_adr_i[23:2]);
  // Flash is mapped twice on the controller; a ROM write would land in the RAM alias
  assign rom_wr       = dbus_we_i && !dbus_adr_i[SEL_BIT];
  assign ram_wr_grant = (state_q == S_IDLE) && pick_d && dbus_we_i && dbus_adr_i[SEL_BIT];
  assign mem_done     = ((state_q == S_MEM_I) || (state_q == S_MEM_D)) && mem_ack_i;

  // Address bits outside the word/region fields carry no meaning here
  logic unused_adr_bits;
  assign unused_adr_bits = ^{ibus_adr_i[31:24], ibus_adr_i[1:0],
                             dbus_adr_i[31:24], dbus_adr_i[1:0]};

  // State register
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: grant in IDLE, leave MEM_x on controller ack, HIT/DROP last one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_d)      state_d = rom_wr   ? S_DROP : S_MEM_D;
        else if (pick_i) state_d = ibuf_hit ? S_HIT  : S_MEM_I;
      end
      S_MEM_I, S_MEM_D: if (mem_ack_i) state_d = S_IDLE;
      S_HIT, S_DROP:    state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Master-side acks and read data; unselected data buses read as zero
  always_comb begin
    ibus_ack_o = 1'b0;
    ibus_dat_o = 32'h0;
    dbus_ack_o = 1'b0;
    dbus_dat_o = 32'h0;
    case (state_q)
      S_MEM_I: if (mem_ack_i) begin
        ibus_ack_o = 1'b1;
        ibus_dat_o = mem_dat_i;
      end
      S_MEM_D: if (mem_ack_i) begin
        dbus_ack_o = 1'b1;
        dbus_dat_o = mem_dat_i;
      end
      S_HIT: begin
        ibus_ack_o = 1'b1;
        ibus_dat_o = buf_dat_q;
      end
      S_DROP:  dbus_ack_o = 1'b1;
      default: ;
    endcase
  end

  // Controller request registers, fairness flag and fetch buffer
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      last_q    <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'h0;
      wdat_q    <= 32'h0;
      adr_q     <= 22'h0;
      sel_q     <= 1'b0;
      buf_vld_q <= 1'b0;
      buf_tag_q <= 22'h0;
      buf_dat_q <= 32'h0;
    end else begin
      last_q    <= last_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdat_q    <= wdat_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      buf_vld_q <= buf_vld_d;
      buf_tag_q <= buf_tag_d;
      buf_dat_q <= buf_dat_d;
    end
  end

  // Capture the granted request; hold it stable until the controller acks
  always_comb begin
    last_d    = last_q;
    stb_d     = stb_q;
    we_d      = we_q;
    be_d      = be_q;
    wdat_d    = wdat_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    buf_vld_d = buf_vld_q;
    buf_tag_d = buf_tag_q;
    buf_dat_d = buf_dat_q;

    if (state_q == S_IDLE) begin
      if (pick_d) begin
        last_d = 1'b1;
        if (!rom_wr) begin
          stb_d  = 1'b1;
          we_d   = dbus_we_i;
          be_d   = dbus_be_i;
          wdat_d = dbus_dat_i;
          adr_d  = dbus_adr_i[23:2];
          sel_d  = dbus_adr_i[SEL_BIT];
        end
      end else if (pick_i) begin
        last_d = 1'b0;
        if (!ibuf_hit) begin
          stb_d  = 1'b1;
          we_d   = 1'b0;
          be_d   = 4'hF;
          wdat_d = 32'h0;
          adr_d  = ibus_adr_i[23:2];
          sel_d  = ibus_adr_i[SEL_BIT];
        end
      end
    end

    // Drop the strobe right after the ack so the controller never sees it stale
    if (mem_done) stb_d = 1'b0;

    if ((state_q == S_MEM_I) && mem_ack_i) begin
      buf_vld_d = 1'b1;
      buf_tag_d = ibus_adr_i[23:2];
      buf_dat_d = mem_dat_i;
    end

    // Invalidation wins over a same-cycle fill
    if (flush_i || (ram_wr_grant && (dbus_adr_i[23:2] == buf_tag_q))) buf_vld_d = 1'b0;
  end

  assign mem_stb_o     = stb_q;
  assign mem_we_o      = we_q;
  assign mem_be_o      = be_q;
  assign mem_dat_o     = wdat_q;
  assign mem_adr_o     = adr_q;
  assign sel_rom_ram_o = sel_q;

endmodule

// File: tb/tb_wb_qspi_arbiter.sv
// Directed per-cycle vector bench for wb_qspi_arbiter.
// Inputs are driven 1 time unit after the rising edge, outputs compared on the falling edge.
// The controller side is scripted: mem_ack_i is raised on fixed cycles by the vectors.
module tb_wb_qspi_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        ibus_stb_i;
  logic [31:0] ibus_adr_i;
  logic        ibus_ack_o;
  logic [31:0] ibus_dat_o;
  logic        dbus_stb_i, dbus_we_i;
  logic [3:0]  dbus_be_i;
  logic [31:0] dbus_adr_i, dbus_dat_i;
  logic        dbus_ack_o;
  logic [31:0] dbus_dat_o;
  logic        flush_i;
  logic        mem_stb_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_dat_o;
  logic [21:0] mem_adr_o;
  logic        sel_rom_ram_o;
  logic        mem_ack_i;
  logic [31:0] mem_dat_i;

  wb_qspi_arbiter #(.SEL_BIT(24), .USE_IBUF(1'b1)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .ibus_stb_i(ibus_stb_i), .ibus_adr_i(ibus_adr_i), .ibus_ack_o(ibus_ack_o), .ibus_dat_o(ibus_dat_o),
    .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i), .dbus_adr_i(dbus_adr_i),
    .dbus_dat_i(dbus_dat_i), .dbus_ack_o(dbus_ack_o), .dbus_dat_o(dbus_dat_o),
    .flush_i(flush_i),
    .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_dat_o(mem_dat_o),
    .mem_adr_o(mem_adr_o), .sel_rom_ram_o(sel_rom_ram_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        istb;
    logic [31:0] iadr;
    logic        dstb;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dadr;
    logic [31:0] ddat;
    logic        flush;
    logic        mack;
    logic [31:0] mdat;
  } in_t;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [21:0] adr;
    logic        sel;
    logic        iack;
    logic [31:0] idat;
    logic        dack;
    logic [31:0] ddat;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic in_t vi(input logic istb, input logic [31:0] iadr, input logic dstb, input logic dwe,
                             input logic [3:0] dbe, input logic [31:0] dadr, input logic [31:0] ddat,
                             input logic fl, input logic mack, input logic [31:0] mdat);
    in_t r;
    r = '{istb, iadr, dstb, dwe, dbe, dadr, ddat, fl, mack, mdat};
    return r;
  endfunction

  function automatic out_t vo(input logic stb, input logic we, input logic [3:0] be, input logic [31:0] wdat,
                              input logic [21:0] adr, input logic sel, input logic iack, input logic [31:0] idat,
                              input logic dack, input logic [31:0] ddat);
    out_t r;
    r = '{stb, we, be, wdat, adr, sel, iack, idat, dack, ddat};
    return r;
  endfunction

  task automatic add(input string name, input in_t i, input out_t o);
    vec_t v;
    v.name = name;
    v.i    = i;
    v.o    = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t v);
    ibus_stb_i = v.istb;
    ibus_adr_i = v.iadr;
    dbus_stb_i = v.dstb;
    dbus_we_i  = v.dwe;
    dbus_be_i  = v.dbe;
    dbus_adr_i = v.dadr;
    dbus_dat_i = v.ddat;
    flush_i    = v.flush;
    mem_ack_i  = v.mack;
    mem_dat_i  = v.mdat;
  endtask

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = {mem_stb_o, mem_we_o, mem_be_o, mem_dat_o, mem_adr_o, sel_rom_ram_o,
           ibus_ack_o, ibus_dat_o, dbus_ack_o, dbus_dat_o};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got stb=%b we=%b be=%h wdat=%h adr=%h sel=%b iack=%b idat=%h dack=%b ddat=%h | want stb=%b we=%b be=%h wdat=%h adr=%h sel=%b iack=%b idat=%h dack=%b ddat=%h",
               name, act.stb, act.we, act.be, act.wdat, act.adr, act.sel, act.iack, act.idat, act.dack, act.ddat,
               exp.stb, exp.we, exp.be, exp.wdat, exp.adr, exp.sel, exp.iack, exp.idat, exp.dack, exp.ddat);
    end
  endtask

  // Run one cycle: drive after the edge, compare mid-cycle
  task automatic step(input string name, input in_t i, input out_t o);
    @(posedge clk_i);
    #1;
    drive(i);
    @(negedge clk_i);
    chk(name, o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  idle_in;
    out_t zero_out;
    idle_in  = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_out = vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- vector table (state continues from the fetch-miss sequence below) ----
    // fetch hit on 0x100
    add("hit_req",   vi(1, 32'h100, 0,0,0,0,0, 0,0,0),                     vo(0,0,4'hF,0,22'h40,0, 0,0,0,0));
    add("hit_ack",   vi(1, 32'h100, 0,0,0,0,0, 0,0,0),                     vo(0,0,4'hF,0,22'h40,0, 1,32'h1111_2222,0,0));
    add("hit_post",  idle_in,                                              vo(0,0,4'hF,0,22'h40,0, 0,0,0,0));
    // flush, then buffer the RAM word 0x0100_0100
    add("flush",     vi(0,0, 0,0,0,0,0, 1,0,0),                            vo(0,0,4'hF,0,22'h40,0, 0,0,0,0));
    add("ram_f_req", vi(1, 32'h0100_0100, 0,0,0,0,0, 0,0,0),               vo(0,0,4'hF,0,22'h40,0, 0,0,0,0));
    add("ram_f_ack", vi(1, 32'h0100_0100, 0,0,0,0,0, 0,1,32'h3333_4444),   vo(1,0,4'hF,0,22'h40,1, 1,32'h3333_4444,0,0));
    add("ram_f_pst", idle_in,                                              vo(0,0,4'hF,0,22'h40,1, 0,0,0,0));
    // RAM write to the buffered word
    add("wr_req",    vi(0,0, 1,1,4'b0010,32'h0100_0100,32'hAABB_CCDD, 0,0,0),           vo(0,0,4'hF,0,22'h40,1, 0,0,0,0));
    add("wr_ack",    vi(0,0, 1,1,4'b0010,32'h0100_0100,32'hAABB_CCDD, 0,1,32'h5555),    vo(1,1,4'b0010,32'hAABB_CCDD,22'h40,1, 0,0,1,32'h5555));
    add("wr_post",   idle_in,                                              vo(0,1,4'b0010,32'hAABB_CCDD,22'h40,1, 0,0,0,0));
    add("refetch",   vi(1, 32'h0100_0100, 0,0,0,0,0, 0,0,0),               vo(0,1,4'b0010,32'hAABB_CCDD,22'h40,1, 0,0,0,0));
    add("refet_ack", vi(1, 32'h0100_0100, 0,0,0,0,0, 0,1,32'hAABB_5566),   vo(1,0,4'hF,0,22'h40,1, 1,32'hAABB_5566,0,0));
    add("refet_pst", idle_in,                                              vo(0,0,4'hF,0,22'h40,1, 0,0,0,0));
    // contention: dbus, then ibus, then dbus again
    add("cont_req",  vi(1,32'h300, 1,0,4'hF,32'h204,0, 0,0,0),             vo(0,0,4'hF,0,22'h40,1, 0,0,0,0));
    add("cont_d1",   vi(1,32'h300, 1,0,4'hF,32'h204,0, 0,1,32'h0D0D_0001), vo(1,0,4'hF,0,22'h81,0, 0,0,1,32'h0D0D_0001));
    add("cont_gap1", vi(1,32'h300, 1,0,4'hF,32'h208,0, 0,0,0),             vo(0,0,4'hF,0,22'h81,0, 0,0,0,0));
    add("cont_i",    vi(1,32'h300, 1,0,4'hF,32'h208,0, 0,1,32'h1C1C_0002), vo(1,0,4'hF,0,22'hC0,0, 1,32'h1C1C_0002,0,0));
    add("cont_gap2", vi(0,0, 1,0,4'hF,32'h208,0, 0,0,0),                   vo(0,0,4'hF,0,22'hC0,0, 0,0,0,0));
    add("cont_wait", vi(0,0, 1,0,4'hF,32'h208,0, 0,0,0),                   vo(1,0,4'hF,0,22'h82,0, 0,0,0,0));
    add("cont_d2",   vi(0,0, 1,0,4'hF,32'h208,0, 0,1,32'h0D0D_0003),       vo(1,0,4'hF,0,22'h82,0, 0,0,1,32'h0D0D_0003));
    // controller ack while idle must be ignored
    add("stray_ack", vi(0,0, 0,0,0,0,0, 0,1,32'hFFFF_FFFF),                vo(0,0,4'hF,0,22'h82,0, 0,0,0,0));
    // ROM write to the buffered word: dropped, buffer keeps 0x300
    add("rom_wr",    vi(0,0, 1,1,4'hF,32'h300,32'h1234_5678, 0,0,0),       vo(0,0,4'hF,0,22'h82,0, 0,0,0,0));
    add("rom_ack",   vi(0,0, 1,1,4'hF,32'h300,32'h1234_5678, 0,0,0),       vo(0,0,4'hF,0,22'h82,0, 0,0,1,0));
    add("rom_hit_r", vi(1,32'h300, 0,0,0,0,0, 0,0,0),                      vo(0,0,4'hF,0,22'h82,0, 0,0,0,0));
    add("rom_hit_a", vi(1,32'h300, 0,0,0,0,0, 0,0,0),                      vo(0,0,4'hF,0,22'h82,0, 1,32'h1C1C_0002,0,0));
    add("rom_post",  idle_in,                                              vo(0,0,4'hF,0,22'h82,0, 0,0,0,0));
    // flush coincident with a fill
    add("ff_req",    vi(1,32'h400, 0,0,0,0,0, 0,0,0),                      vo(0,0,4'hF,0,22'h82,0, 0,0,0,0));
    add("ff_ack",    vi(1,32'h400, 0,0,0,0,0, 1,1,32'h4444_0004),          vo(1,0,4'hF,0,22'h100,0, 1,32'h4444_0004,0,0));
    add("ff_post",   idle_in,                                              vo(0,0,4'hF,0,22'h100,0, 0,0,0,0));
    add("ff_req2",   vi(1,32'h400, 0,0,0,0,0, 0,0,0),                      vo(0,0,4'hF,0,22'h100,0, 0,0,0,0));
    add("ff_miss",   vi(1,32'h400, 0,0,0,0,0, 0,0,0),                      vo(1,0,4'hF,0,22'h100,0, 0,0,0,0));
    add("ff_ack2",   vi(1,32'h400, 0,0,0,0,0, 0,1,32'h4444_0005),          vo(1,0,4'hF,0,22'h100,0, 1,32'h4444_0005,0,0));
    add("ff_post2",  idle_in,                                              vo(0,0,4'hF,0,22'h100,0, 0,0,0,0));

    // ---- reset ----
    rst_in = 1'b0;
    drive(idle_in);
    #2;
    chk("reset", zero_out);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_in = 1'b1;
    @(negedge clk_i);
    chk("reset_rel", zero_out);

    // ---- single fetch miss, controller acks 6 cycles after strobe ----
    step("miss_req", vi(1,32'h100, 0,0,0,0,0, 0,0,0), zero_out);
    for (int k = 1; k <= 6; k++)
      step("miss_wait", vi(1,32'h100, 0,0,0,0,0, 0,0,0), vo(1,0,4'hF,0,22'h40,0, 0,0,0,0));
    step("miss_ack",  vi(1,32'h100, 0,0,0,0,0, 0,1,32'h1111_2222), vo(1,0,4'hF,0,22'h40,0, 1,32'h1111_2222,0,0));
    step("miss_post", idle_in, vo(0,0,4'hF,0,22'h40,0, 0,0,0,0));

    // ---- table ----
    for (int v = 0; v < tbl.size(); v++)
      step(tbl[v].name, tbl[v].i, tbl[v].o);

    // ---- reset during MEM_D ----
    step("rst_d_req", vi(0,0, 1,0,4'hF,32'h0100_0010,0, 0,0,0), vo(0,0,4'hF,0,22'h100,0, 0,0,0,0));
    step("rst_d_mem", vi(0,0, 1,0,4'hF,32'h0100_0010,0, 0,0,0), vo(1,0,4'hF,0,22'h004,1, 0,0,0,0));
    #1;
    mem_ack_i = 1'b1;
    mem_dat_i = 32'hDEAD_BEEF;
    rst_in    = 1'b0;
    #1;
    chk("rst_async", zero_out);
    drive(idle_in);
    @(posedge clk_i);
    #1 rst_in = 1'b1;
    @(negedge clk_i);
    chk("rst_idle", zero_out);
    // buffer must be empty after reset: 0x100 misses again
    step("rst_f_req", vi(1,32'h100, 0,0,0,0,0, 0,0,0), zero_out);
    step("rst_f_mem", vi(1,32'h100, 0,0,0,0,0, 0,0,0), vo(1,0,4'hF,0,22'h40,0, 0,0,0,0));

    @(posedge clk_i);
    #1 drive(idle_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_qspi_arbiter.md
# wb_qspi_arbiter

Sits between the core's instruction and data Wishbone ports and the single QSPI memory controller, and shares that controller between the two buses. It arbitrates between the buses, decodes the ROM/RAM region and drives the controller's `sel_rom_ram` input. It absorbs writes aimed at flash and serves repeated instruction fetches from a one-word fetch buffer. Only one QSPI transaction is ever outstanding.

## Interface
- `SEL_BIT`, default 24: byte-address bit that selects the region (0 = ROM, 1 = RAM).
- `USE_IBUF`, default 1: enables the one-word instruction fetch buffer. At 0, every fetch goes to memory.
- `clk_i` in 1: single clock, all state on its rising edge.
- `rst_in` in 1: reset, asynchronous and active-low.
- `ibus_stb_i` in 1: instruction read request, held until `ibus_ack_o`.
- `ibus_adr_i` in 32: instruction byte address; bits [1:0] are ignored.
- `ibus_ack_o` out 1: instruction ack, one cycle.
- `ibus_dat_o` out 32: instruction data, valid while `ibus_ack_o` is high.
- `dbus_stb_i` in 1: data request, held until `dbus_ack_o`.
- `dbus_we_i` in 1: data write enable.
- `dbus_be_i` in 4: byte enables; never 4'b0000.
- `dbus_adr_i` in 32: data byte address.
- `dbus_dat_i` in 32: write data.
- `dbus_ack_o` out 1: data ack, one cycle.
- `dbus_dat_o` out 32: read data, valid while `dbus_ack_o` is high.
- `flush_i` in 1: one-cycle fetch-buffer invalidate (fence.i).
- `mem_stb_o` out 1: controller request.
- `mem_we_o` out 1: controller write enable.
- `mem_be_o` out 4: controller byte enables.
- `mem_dat_o` out 32: controller write data.
- `mem_adr_o` out 22: controller word address, equal to `adr[23:2]` of the granted bus.
- `sel_rom_ram_o` out 1: region select; 1 = RAM, 0 = ROM.
- `mem_ack_i` in 1: controller ack.
- `mem_dat_i` in 32: controller read data.

## Operation
- **States:**
  - IDLE: arbitrate.
  - MEM_I: instruction transaction in flight.
  - MEM_D: data transaction in flight.
  - HIT: fetch served from the buffer.
  - DROP: write to ROM discarded.
- **Arbitration** happens only in IDLE.
  - The candidates are `dbus_stb_i` and `ibus_stb_i`.
  - If both request, the bus not granted last wins. The `last_d` flag resets to 0, so data wins the first contest.
  - An ibus read whose word address equals the buffer tag, with the buffer valid and `USE_IBUF=1`, goes to HIT instead of MEM_I.
  - A dbus write with `adr[SEL_BIT]=0` goes to DROP. It is never forwarded, because the controller would otherwise write the RAM alias.
  - A dbus read from ROM is forwarded normally.
- **On grant to MEM_x:** `mem_adr_o`, `mem_we_o`, `mem_be_o`, `mem_dat_o` and `sel_rom_ram_o` are registered from the granted bus. `mem_stb_o` is then set to 1.
  - These outputs, including `sel_rom_ram_o`, hold stable until `mem_ack_i`.
  - An ibus grant drives `mem_we_o=0` and `mem_be_o=4'hF`.
- **In MEM_x on `mem_ack_i`:**
  - The granted bus's ack is driven combinationally in the same cycle, with `x_dat_o = mem_dat_i`.
  - `mem_stb_o` is cleared at the next edge and the state returns to IDLE.
  - For MEM_I, the buffer loads tag = `ibus_adr_i[23:2]`, data = `mem_dat_i` and valid = 1.
- **HIT and DROP:** each lasts one cycle and asserts its bus's ack registered.
  - HIT drives `ibus_dat_o` = buffer data.
  - DROP drives `dbus_dat_o` = 0.
  - Both return to IDLE.
- **Buffer invalidation:** valid clears on `flush_i`, and on a dbus RAM-write grant whose word address equals the tag. Invalidation has priority over a fill in the same cycle.
- **Unselected data outputs** read as 0.

## Timing
- **Reset values:** all outputs are 0; state IDLE, `last_d=0`, buffer invalid. Assertion mid-transaction aborts immediately. The controller shares `rst_in`, so no partial QSPI transfer survives.
- **Memory path:**
  - A request at cycle 0 in IDLE gives `mem_stb_o=1` at cycle 1.
  - Master ack coincides with the cycle of `mem_ack_i`.
  - `mem_stb_o=0` in the cycle after the ack, so the controller in IDLE never sees a stale strobe.
  - The earliest next grant is evaluated in that post-ack cycle, with `mem_stb_o` high one cycle later.
- **HIT and DROP latency:** request at cycle 0, ack at cycle 1, next arbitration at cycle 2.
- **Masters:** a master may keep `stb` high the cycle after its ack. This is treated as a new request.
- **Unexpected controller ack:** `mem_ack_i` outside MEM_x is ignored.

## Test plan
- **Single fetch miss:** ibus read 0x0000_0100 with the controller model acking 6 cycles after `mem_stb_o` → `mem_adr_o`=0x40, `sel_rom_ram_o`=0, `ibus_dat_o`=model data on ack, `mem_stb_o` low the next cycle.
- **Fetch hit:** repeat the fetch of 0x100 → `ibus_ack_o` one cycle later, no `mem_stb_o` pulse, same data.
- **Invalidating write:** dbus write 0x0100_0100 with be=4'b0010, then ibus fetch 0x0100_0100 (RAM) after buffering it → buffer invalidated; the fetch goes to memory with `sel_rom_ram_o`=1 and returns the new word.
- **Contention:** ibus and dbus both request in IDLE, back-to-back → dbus served first, ibus second, then dbus again. No grant overlaps and `mem_stb_o` has a low cycle between transactions.
- **ROM write:** dbus write to 0x0000_0200 → `dbus_ack_o` at cycle 1, `mem_stb_o` stays 0, buffer unaffected.
- **Reset and flush:** `rst_in` low during MEM_D → all outputs 0 asynchronously, IDLE after release. `flush_i` coincident with a fill ack → buffer invalid afterwards.
